scorehand_acc: RTL and testbench

Sequential, parametrised successor to the combinational hand scorer. Accepts cards one per cycle over a valid/ready handshake and keeps a registered running score (modulo MODULUS, face cards worth zero) and a card count. Flags a natural, a full hand and illegal card codes. Sits between the card-dealing datapath and the game-control FSM, so the controller reads score and status directly instead of re-summing stored cards.

---
 rtl/scorehand_pkg.sv | 17 +
 rtl/scorehand_acc_card_value.sv | 25 ++
 rtl/scorehand_acc.sv | 134 +++++++++++++
 tb/tb_scorehand_acc.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/scorehand_pkg.sv
// Shared defaults and hand-state type for the sequential hand scorer.
package scorehand_pkg;

    localparam int unsigned DEF_MAX_CARDS   = 3;
    localparam int unsigned DEF_CARD_W      = 4;
    localparam int unsigned DEF_MAX_RANK    = 13;
    localparam int unsigned DEF_FACE_THRESH = 9;
    localparam int unsigned DEF_MODULUS     = 10;
    localparam int unsigned DEF_SCORE_W     = 4;

    typedef enum logic [1:0] {
        HAND_EMPTY,
        HAND_PARTIAL,
        HAND_FULL
    } hand_state_e;

endpackage

// File: rtl/scorehand_acc_card_value.sv
// Combinational card decoder: maps a card code to its score value and legality.
module card_value #(
    parameter int unsigned CARD_W      = 4,
    parameter int unsigned MAX_RANK    = 13,
    parameter int unsigned FACE_THRESH = 9,
    parameter int unsigned SCORE_W     = 4
) (
    input  logic [CARD_W-1:0]  card,
    output logic [SCORE_W-1:0] value,
    output logic               legal
);

    localparam logic [CARD_W-1:0] MaxRankC = CARD_W'(MAX_RANK);
    localparam logic [CARD_W-1:0] FaceC    = CARD_W'(FACE_THRESH);

    // Legal codes are 1..MAX_RANK; faces and illegal codes contribute nothing.
    always_comb begin
        legal = (card != '0) && (card <= MaxRankC);
        value = '0;
        if (legal && (card <= FaceC)) begin
            value = SCORE_W'(card);
        end
    end

endmodule

// File: rtl/scorehand_acc.sv
// Sequential hand scorer: accumulates cards over valid/ready, keeps a
// modulo running score, card count and status flags for the game controller.
module scorehand_acc
    import scorehand_pkg::*;
#(
    parameter int unsigned MAX_CARDS   = DEF_MAX_CARDS,
    parameter int unsigned CARD_W      = DEF_CARD_W,
    parameter int unsigned MAX_RANK    = DEF_MAX_RANK,
    parameter int unsigned FACE_THRESH = DEF_FACE_THRESH,
    parameter int unsigned MODULUS     = DEF_MODULUS,
    parameter int unsigned SCORE_W     = DEF_SCORE_W,
    parameter int unsigned CNT_W       = $clog2(MAX_CARDS + 1)
) (
    input  logic               slow_clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               card_valid,
    input  logic [CARD_W-1:0]  card,
    output logic               card_ready,
    output logic [SCORE_W-1:0] score,
    output logic [CNT_W-1:0]   count,
    output logic               score_valid,
    output logic               full,
    output logic               natural,
    output logic               card_err
);

    // Parameter sanity, caught at elaboration.
    if (FACE_THRESH >= MODULUS) begin : g_chk_face
        $fatal(1, "scorehand_acc: FACE_THRESH must be below MODULUS");
    end
    if (64'(MODULUS) > (64'(1) << SCORE_W)) begin : g_chk_mod
        $fatal(1, "scorehand_acc: MODULUS does not fit SCORE_W");
    end
    if (MAX_CARDS < 2) begin : g_chk_cards
        $fatal(1, "scorehand_acc: MAX_CARDS must be at least 2");
    end

    localparam logic [CNT_W-1:0]   MaxC    = CNT_W'(MAX_CARDS);
    localparam logic [CNT_W-1:0]   TwoC    = CNT_W'(2);
    localparam logic [SCORE_W:0]   ModC    = (SCORE_W + 1)'(MODULUS);
    localparam logic [SCORE_W-1:0] NatMinC = SCORE_W'(MODULUS - 2);

    hand_state_e          state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 sv_q, sv_d;
    logic                 err_q, err_d;

    logic [SCORE_W-1:0]   value;
    logic                 legal;
    logic [SCORE_W:0]     sum;
    logic                 take;
    logic                 accept;

    card_value #(
        .CARD_W      (CARD_W),
        .MAX_RANK    (MAX_RANK),
        .FACE_THRESH (FACE_THRESH),
        .SCORE_W     (SCORE_W)
    ) u_card_value (
        .card  (card),
        .value (value),
        .legal (legal)
    );

    assign card_ready = (count_q < MaxC);
    assign take       = card_valid && card_ready;
    assign accept     = take && legal;
    // One extra bit so the wrap test sees the true sum before reduction.
    assign sum        = {1'b0, score_q} + {1'b0, value};

    // Datapath next-state: clear wins over the handshake and drops any card.
    always_comb begin
        score_d = score_q;
        count_d = count_q;
        sv_d    = 1'b0;
        err_d   = err_q;
        if (clear) begin
            score_d = '0;
            count_d = '0;
            err_d   = 1'b0;
        end else if (accept) begin
            score_d = (sum >= ModC) ? SCORE_W'(sum - ModC) : SCORE_W'(sum);
            count_d = count_q + CNT_W'(1);
            sv_d    = 1'b1;
        end else if (take) begin
            err_d   = 1'b1;
        end
    end

    // Hand-state transitions, tracking the count of accepted cards.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = HAND_EMPTY;
        end else begin
            unique case (state_q)
                HAND_EMPTY, HAND_PARTIAL: begin
                    if (accept) begin
                        state_d = (count_q + CNT_W'(1) == MaxC) ? HAND_FULL : HAND_PARTIAL;
                    end
                end
                HAND_FULL: state_d = HAND_FULL;
                default:   state_d = HAND_EMPTY;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state_q <= HAND_EMPTY;
            score_q <= '0;
            count_q <= '0;
            sv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            count_q <= count_d;
            sv_q    <= sv_d;
            err_q   <= err_d;
        end
    end

    assign score       = score_q;
    assign count       = count_q;
    assign score_valid = sv_q;
    assign card_err    = err_q;
    assign full        = (state_q == HAND_FULL);
    assign natural     = (count_q == TwoC) && (score_q >= NatMinC);

endmodule

// File: tb/tb_scorehand_acc.sv
// Bench for scorehand_acc: a 3-card and a 5-card instance share one stimulus
// stream and are each compared with a count/sum model of the hand.
module tb_scorehand_acc;

    logic       slow_clock;
    logic       reset, clear, card_valid;
    logic [3:0] card;

    logic       ready3, ready5;
    logic [3:0] score3, score5;
    logic [1:0] count3;
    logic [2:0] count5;
    logic       sv3, sv5, full3, full5, nat3, nat5, err3, err5;

    int tests = 0;
    int fails = 0;

    // Model: number of accepted cards and plain sum of their values.
    int m_cnt [2];
    int m_sum [2];
    bit m_err [2];
    bit m_sv  [2];
    int mc    [2] = '{3, 5};

    scorehand_acc #(.MAX_CARDS(3)) u_dut3 (
        .slow_clock  (slow_clock),
        .reset       (reset),
        .clear       (clear),
        .card_valid  (card_valid),
        .card        (card),
        .card_ready  (ready3),
        .score       (score3),
        .count       (count3),
        .score_valid (sv3),
        .full        (full3),
        .natural     (nat3),
        .card_err    (err3)
    );

    scorehand_acc #(.MAX_CARDS(5), .MODULUS(10)) u_dut5 (
        .slow_clock  (slow_clock),
        .reset       (reset),
        .clear       (clear),
        .card_valid  (card_valid),
        .card        (card),
        .card_ready  (ready5),
        .score       (score5),
        .count       (count5),
        .score_valid (sv5),
        .full        (full5),
        .natural     (nat5),
        .card_err    (err5)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            string p;
            int    sc;
            p  = $sformatf("max%0d", mc[i]);
            sc = m_sum[i] % 10;
            chk({p, " score"}, (i == 0) ? 32'(score3) : 32'(score5), sc);
            chk({p, " count"}, (i == 0) ? 32'(count3) : 32'(count5), m_cnt[i]);
            chk({p, " ready"}, (i == 0) ? 32'(ready3) : 32'(ready5), 32'(m_cnt[i] < mc[i]));
            chk({p, " full"}, (i == 0) ? 32'(full3) : 32'(full5), 32'(m_cnt[i] == mc[i]));
            chk({p, " natural"}, (i == 0) ? 32'(nat3) : 32'(nat5),
                32'((m_cnt[i] == 2) && (sc >= 8)));
            chk({p, " card_err"}, (i == 0) ? 32'(err3) : 32'(err5), 32'(m_err[i]));
            chk({p, " score_valid"}, (i == 0) ? 32'(sv3) : 32'(sv5), 32'(m_sv[i]));
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare.
    task automatic step(input bit v, input int c, input bit clr, input bit rst);
        card_valid = v;
        card       = 4'(c);
        clear      = clr;
        reset      = rst;
        @(posedge slow_clock);
        for (int i = 0; i < 2; i++) begin
            m_sv[i] = 1'b0;
            if (rst || clr) begin
                m_cnt[i] = 0;
                m_sum[i] = 0;
                m_err[i] = 1'b0;
            end else if (v && (m_cnt[i] < mc[i])) begin
                if (c >= 1 && c <= 13) begin
                    m_sum[i] += (c > 9) ? 0 : c;
                    m_cnt[i]++;
                    m_sv[i] = 1'b1;
                end else begin
                    m_err[i] = 1'b1;
                end
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; card_valid = 1'b0; card = '0;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_sum[i] = 0; m_err[i] = 0; m_sv[i] = 0;
        end

        step(0, 0, 0, 1);
        chk("reset ready", 32'(ready3), 1);
        step(0, 0, 0, 0);

        // 7, 9, 12 -> 7, 6, 6 with the hand full after the third card
        step(1, 7, 0, 0);
        chk("tp1 score a", 32'(score3), 7);
        chk("tp1 sv a", 32'(sv3), 1);
        step(1, 9, 0, 0);
        chk("tp1 score b", 32'(score3), 6);
        step(1, 12, 0, 0);
        chk("tp1 score c", 32'(score3), 6);
        chk("tp1 count c", 32'(count3), 3);
        chk("tp1 full", 32'(full3), 1);
        chk("tp1 ready", 32'(ready3), 0);
        chk("tp1 sv c", 32'(sv3), 1);

        // Full hand ignores a further card
        step(1, 5, 0, 0);
        chk("full ignore score", 32'(score3), 6);
        chk("full ignore sv", 32'(sv3), 0);

        // Natural on 4, 4, lost on the third card
        step(0, 0, 1, 0);
        step(1, 4, 0, 0);
        step(1, 4, 0, 0);
        chk("nat score", 32'(score3), 8);
        chk("nat flag", 32'(nat3), 1);
        step(1, 13, 0, 0);
        chk("nat3 flag", 32'(nat3), 0);
        chk("nat3 full", 32'(full3), 1);

        // Illegal codes set the sticky error, clear removes it
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        step(1, 14, 0, 0);
        chk("err flag", 32'(err3), 1);
        chk("err count", 32'(count3), 0);
        step(1, 3, 0, 0);
        chk("err legal score", 32'(score3), 3);
        chk("err sticky", 32'(err3), 1);
        step(0, 0, 1, 0);
        chk("err cleared", 32'(err3), 0);

        // Clear together with a card drops the card
        step(1, 6, 0, 0);
        step(1, 5, 0, 0);
        step(1, 2, 1, 0);
        chk("clr score", 32'(score3), 0);
        chk("clr sv", 32'(sv3), 0);
        chk("clr ready", 32'(ready3), 1);

        // Reset together with a card drops the card
        step(1, 9, 0, 0);
        step(1, 9, 0, 0);
        step(1, 9, 0, 1);
        chk("rst count", 32'(count3), 0);

        // Five nines on the 5-card hand -> 45 mod 10
        for (int k = 0; k < 5; k++) step(1, 9, 0, 0);
        chk("max5 score", 32'(score5), 5);
        chk("max5 full", 32'(full5), 1);

        // Randomized traffic
        repeat (400) begin
            int r;
            r = $urandom_range(0, 31);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15), (r == 1) || (r == 2), r == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
